word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-to-serial front end for the bit-serial two's-complement datapath. Accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB-first, one bit per clock. Before each word it emits a one-cycle clear pulse so the downstream serial complementer FSM restarts at every word boundary. Sits directly upstream of the twoBitsComplement stage: bitOut drives its bitIn, and clrOut (ORed with system rst at top level) drives its rst.

## Interface
- WIDTH, 8, word length in bits (≥2); counter width is derived as $clog2(WIDTH).
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- dataIn  input  WIDTH  parallel word; sampled only on acceptance.
- loadValid  input  1  producer offers dataIn.
- loadReady  output  1  block can accept a word this cycle.
- clrOut  output  1  one-cycle clear pulse to the downstream FSM, issued before the first bit.
- bitOut  output  1  current serial bit, LSB first; 0 when bitValid=0.
- bitValid  output  1  bitOut carries a data bit.
- lastBit  output  1  bitOut is the MSB (final bit of the word).

## Operation
- States: IDLE, CLEAR, SHIFT. Register shiftReg[WIDTH-1:0], bitCnt.
- Acceptance: loadValid && loadReady sampled at a rising edge. Captures dataIn into shiftReg, sets bitCnt=0, next state CLEAR.
- IDLE: loadReady=1. All other outputs 0. Stays in IDLE until acceptance.
- CLEAR: clrOut=1, loadReady=0, bitValid=0. Unconditional transition to SHIFT.
- SHIFT: bitValid=1, bitOut=shiftReg[0]. Each cycle shiftReg shifts right (zero fill) and bitCnt increments.
- Last SHIFT cycle (bitCnt==WIDTH-1): lastBit=1 and loadReady=1.
  - Acceptance in that cycle goes to CLEAR with the new word (back-to-back).
  - Otherwise the next state is IDLE.
- loadValid while loadReady=0 is ignored; the producer must hold it.
- dataIn changes after acceptance have no effect on the word in flight.
- Outputs are decoded from state, bitCnt and shiftReg only. There is no combinational path from any input to any output.

## Timing
- While rst=1: next state IDLE, shiftReg=0, bitCnt=0. All outputs are forced to 0, including loadReady; loads are ignored.
- First cycle after rst deasserts: loadReady=1, all other outputs 0.
- Acceptance at edge k:
  - clrOut high during cycle k→k+1.
  - Bit i valid during cycle k+1+i → k+2+i, for i = 0..WIDTH-1.
  - lastBit high with bit WIDTH-1.
- Sustained throughput: one word per WIDTH+1 cycles, with no idle cycle between words when loadValid is held high.
- Reset mid-word: on the next cycle bitValid, clrOut and lastBit are 0. The word is dropped and lastBit is never asserted for it.
- Simultaneous rst and loadValid: rst wins and no word is captured.

## Structure
- Package serial_pkg holds the state enum (IDLE, CLEAR, SHIFT) and the default WIDTH constant, shared with later serial stages (the deserializer).
- No sub-module. Counter and shift register are inline.
- Chaining this block with the complementer belongs to a separate top-level wrapper and is out of scope here.

## Test plan
All scenarios use WIDTH=8 unless stated.
- Basic word: after reset, load 8'h0B.
  - clrOut for 1 cycle.
  - bitOut = 1,1,0,1,0,0,0,0 with bitValid high for 8 cycles; lastBit only on the 8th.
  - Chained with the complementer, the collected output is 8'hF5.
- Back-to-back: hold loadValid with 8'hA5 then 8'h3C.
  - The second word is accepted on the lastBit cycle, and clrOut follows immediately.
  - Period is exactly 9 cycles; bit streams are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- Busy ignore: assert loadValid with 8'hFF during SHIFT of 8'h01.
  - No capture: loadReady=0 and the 8'h01 stream is unchanged.
  - Toggling dataIn mid-word has no effect.
- Reset mid-word: load 8'hFF and assert rst after 3 bits.
  - bitValid=0 on the next cycle and lastBit is never seen.
  - loadReady=1 in the first cycle after rst falls.
- Idle hold: loadValid=0 for 20 cycles after reset.
  - loadReady stays 1; bitValid, clrOut, lastBit and bitOut stay 0.
- WIDTH=2: load 2'b10.
  - clrOut, then bits 0,1 with lastBit on the second; a new load is accepted in that cycle.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial datapath stages
// (serializer now, deserializer later).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } serState_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: accepts a word on valid/ready, emits a clear
// pulse for the downstream complementer, then shifts the word out LSB first.
module word_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             loadValid,
  output logic             loadReady,
  output logic             clrOut,
  output logic             bitOut,
  output logic             bitValid,
  output logic             lastBit
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  serState_t        state;
  serState_t        nextState;
  logic [WIDTH-1:0] shiftReg;
  logic [CW-1:0]    bitCnt;
  logic             inReset;
  logic             accept;
  logic             atLast;

  // inReset is a registered copy of rst so outputs can be held at zero during
  // reset without any combinational path from an input to an output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      inReset <= 1'b1;
    end else begin
      state   <= nextState;
      inReset <= 1'b0;
    end
  end

  assign atLast = (state == SHIFT) && (bitCnt == LAST_CNT);
  assign accept = loadValid && loadReady;

  // A load in the final SHIFT cycle wins over the shift so words chain with
  // no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      shiftReg <= '0;
      bitCnt   <= '0;
    end else if (accept) begin
      shiftReg <= dataIn;
      bitCnt   <= '0;
    end else if (state == SHIFT) begin
      shiftReg <= {1'b0, shiftReg[WIDTH-1:1]};
      bitCnt   <= bitCnt + CW'(1);
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = CLEAR;
      CLEAR:   nextState = SHIFT;
      SHIFT:   if (atLast) nextState = accept ? CLEAR : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    loadReady = 1'b0;
    clrOut    = 1'b0;
    bitOut    = 1'b0;
    bitValid  = 1'b0;
    lastBit   = 1'b0;
    if (!inReset) begin
      case (state)
        IDLE: loadReady = 1'b1;
        CLEAR: clrOut = 1'b1;
        SHIFT: begin
          bitValid  = 1'b1;
          bitOut    = shiftReg[0];
          lastBit   = atLast;
          loadReady = atLast;
        end
        default: loadReady = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed self-checking bench for word_serializer at WIDTH=8 and WIDTH=2.
module tb_word_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] data8 = '0;
  logic       valid8 = 1'b0;
  logic       ready8, clr8, bit8, bitValid8, last8;

  logic [1:0] data2 = '0;
  logic       valid2 = 1'b0;
  logic       ready2, clr2, bit2, bitValid2, last2;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .dataIn(data8), .loadValid(valid8),
    .loadReady(ready8), .clrOut(clr8), .bitOut(bit8),
    .bitValid(bitValid8), .lastBit(last8)
  );

  word_serializer #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .dataIn(data2), .loadValid(valid2),
    .loadReady(ready2), .clrOut(clr2), .bitOut(bit2),
    .bitValid(bitValid2), .lastBit(last2)
  );

  // Output bundles ordered {loadReady, bitValid, clrOut, lastBit, bitOut}.
  wire [4:0] outs8 = {ready8, bitValid8, clr8, last8, bit8};
  wire [4:0] outs2 = {ready2, bitValid2, clr2, last2, bit2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference serial two's-complement: copy bits up to and including the
  // first 1, invert the rest.
  function automatic logic [7:0] twosSerial(input logic [7:0] b);
    logic seen;
    logic [7:0] r;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[i] ^ seen;
      seen = seen | b[i];
    end
    return r;
  endfunction

  // Entered in the CLEAR cycle; leaves in the cycle after the last bit.
  task automatic applyStimulus(input string tag, input logic [7:0] word,
                               input logic nextValid, input logic poke,
                               output logic [7:0] collected);
    checkOutput({tag, "/clr"}, outs8, 32'b00100);
    tick();
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s/bit%0d", tag, i), outs8,
                  {27'd0, (i == 7), 1'b1, 1'b0, (i == 7), word[i]});
      collected[i] = bit8;
      if (i == 0) valid8 = nextValid;
      if (poke && i >= 1 && i <= 5) begin
        valid8 = 1'b1;
        data8  = 8'($urandom);
      end else if (poke && i == 6) begin
        valid8 = 1'b0;
      end
      tick();
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst/outs8", outs8, 32'b00000);
    checkOutput("rst/outs2", outs2, 32'b00000);
    rst = 1'b0;
    tick();
    checkOutput("postrst/outs8", outs8, 32'b10000);
    checkOutput("postrst/outs2", outs2, 32'b10000);
  endtask

  initial begin
    logic [7:0] col;

    tick();
    doReset();

    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("idle/c%0d", i), outs8, 32'b10000);
      tick();
    end

    data8 = 8'h0B;
    valid8 = 1'b1;
    checkOutput("basic/ready", ready8, 1'b1);
    tick();
    valid8 = 1'b0;
    data8 = 8'h00;
    applyStimulus("basic", 8'h0B, 1'b0, 1'b0, col);
    checkOutput("basic/twos", twosSerial(col), 8'hF5);
    checkOutput("basic/idle", outs8, 32'b10000);

    data8 = 8'hA5;
    valid8 = 1'b1;
    tick();
    data8 = 8'h3C;
    applyStimulus("b2bA", 8'hA5, 1'b1, 1'b0, col);
    data8 = 8'h00;
    applyStimulus("b2bB", 8'h3C, 1'b0, 1'b0, col);
    checkOutput("b2b/idle", outs8, 32'b10000);

    data8 = 8'h01;
    valid8 = 1'b1;
    tick();
    valid8 = 1'b0;
    data8 = 8'hFF;
    applyStimulus("busy", 8'h01, 1'b0, 1'b1, col);
    checkOutput("busy/idle", outs8, 32'b10000);

    data8 = 8'hFF;
    valid8 = 1'b1;
    tick();
    valid8 = 1'b0;
    checkOutput("midrst/clr", outs8, 32'b00100);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("midrst/bit%0d", i), outs8, 32'b01001);
      tick();
    end
    checkOutput("midrst/bit3", outs8, 32'b01001);
    rst = 1'b1;
    valid8 = 1'b1;
    data8 = 8'hAA;
    tick();
    checkOutput("midrst/drop", outs8, 32'b00000);
    tick();
    checkOutput("midrst/hold", outs8, 32'b00000);
    rst = 1'b0;
    valid8 = 1'b0;
    tick();
    checkOutput("midrst/ready", outs8, 32'b10000);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("midrst/nolast%0d", i), outs8, 32'b10000);
    end

    data2 = 2'b10;
    valid2 = 1'b1;
    tick();
    data2 = 2'b01;
    checkOutput("w2/clr", outs2, 32'b00100);
    tick();
    checkOutput("w2/bit0", outs2, 32'b01000);
    tick();
    checkOutput("w2/bit1", outs2, 32'b11011);
    tick();
    valid2 = 1'b0;
    checkOutput("w2/clr2", outs2, 32'b00100);
    tick();
    checkOutput("w2/b2bit0", outs2, 32'b01001);
    tick();
    checkOutput("w2/b2bit1", outs2, 32'b11010);
    tick();
    checkOutput("w2/idle", outs2, 32'b10000);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
